// File: rtl/speed_ascii_pkg.sv
// -----------------------------------------------------------------------------
// speed_ascii_pkg
// Shared definitions for the speed-to-ASCII framer:
//   state_t     - framer FSM states (IDLE, CONVERT, EMIT)
//   ASCII_*     - character constants used when building a frame
//   min_digits  - smallest decimal digit count able to hold 2^width-1,
//                 used for the elaboration-time parameter check
// -----------------------------------------------------------------------------
package speed_ascii_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Smallest d such that 10^d > 2^width - 1 (valid for width up to 63).
  function automatic int min_digits(input int width);
    longint unsigned max_val;
    longint unsigned pow10;
    int              digits;
    max_val = (64'd1 << width) - 64'd1;
    pow10   = 64'd10;
    digits  = 1;
    while (pow10 <= max_val) begin
      pow10  = pow10 * 64'd10;
      digits = digits + 1;
    end
    return digits;
  endfunction

endpackage

// File: rtl/speed_ascii_framer_if.sv
// -----------------------------------------------------------------------------
// speed_ascii_framer_if
// Bundles the sample strobe and the FIFO write side of the framer.
//   done      - one-cycle strobe, speed valid
//   speed     - binary speed sample
//   fifo_full - downstream FIFO full flag
//   write     - FIFO write strobe
//   data      - byte presented with write (ASCII in [7:0])
//   busy      - frame in conversion or emission
//   overrun   - pulse: a sample was dropped because the framer was busy
// Modports: master = framer side, slave = producer/FIFO side.
// -----------------------------------------------------------------------------
interface speed_ascii_framer_if #(
  parameter int WIDTH_SPEED = 14,
  parameter int DATA_SIZE   = 8
);

  logic                   done;
  logic [WIDTH_SPEED-1:0] speed;
  logic                   fifo_full;
  logic                   write;
  logic [DATA_SIZE-1:0]   data;
  logic                   busy;
  logic                   overrun;

  modport master (
    input  done, speed, fifo_full,
    output write, data, busy, overrun
  );

  modport slave (
    output done, speed, fifo_full,
    input  write, data, busy, overrun
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative double-dabble converter, one bit per clock.
//   clk, reset_n - clock, asynchronous active-low reset
//   start        - load bin, clear BCD and begin WIDTH shift cycles
//   bin          - binary value to convert
//   bcd          - packed BCD result, most significant digit in the top nibble
//   done_conv    - high during the cycle that performs the final shift;
//                  bcd holds the complete result from the next cycle on
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import speed_ascii_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done_conv
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]    bin_r;
  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] bcd_adj_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                active_r;

  // Add-3 correction on every nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
  end

  // Shift register {bcd, bin}, bit counter and run flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_r    <= '0;
      bcd_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
    end else if (start) begin
      bin_r    <= bin;
      bcd_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b1;
    end else if (active_r) begin
      {bcd_r, bin_r} <= {bcd_adj_s[4*DIGITS-2:0], bin_r, 1'b0};
      if (cnt_r == LAST_BIT) begin
        cnt_r    <= '0;
        active_r <= 1'b0;
      end else begin
        cnt_r    <= cnt_r + CNT_W'(1);
      end
    end else begin
      bin_r    <= bin_r;
      bcd_r    <= bcd_r;
      cnt_r    <= cnt_r;
      active_r <= active_r;
    end
  end

  assign bcd       = bcd_r;
  assign done_conv = active_r && (cnt_r == LAST_BIT);

endmodule

// File: rtl/speed_ascii_framer.sv
// -----------------------------------------------------------------------------
// speed_ascii_framer
// Converts a binary speed sample to decimal ASCII and pushes
// "<digits>\r\n" into a UART transmit FIFO one byte per cycle.
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   bus     - speed_ascii_framer_if.master (done/speed in, FIFO write out,
//             busy, overrun)
// Optional build macro SPEED_ASCII_LZS_EN: suppress leading zero digits
// (the last digit is always sent, so 0 becomes "0\r\n").
// -----------------------------------------------------------------------------
module speed_ascii_framer
  import speed_ascii_pkg::*;
#(
  parameter int WIDTH_SPEED = 14,
  parameter int NUM_DIGITS  = 5,
  parameter int DATA_SIZE   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  speed_ascii_framer_if.master   bus
);

  if (NUM_DIGITS < min_digits(WIDTH_SPEED)) begin : g_digits_check
    $error("speed_ascii_framer: NUM_DIGITS cannot represent 2^WIDTH_SPEED-1");
  end
  if (DATA_SIZE < 8) begin : g_data_check
    $error("speed_ascii_framer: DATA_SIZE must be at least 8");
  end

  // Character index runs over the digits, then CR, then LF.
  localparam int               IDX_W    = $clog2(NUM_DIGITS + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS + 1);
  localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(NUM_DIGITS);

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W-1:0]        eff_idx_s;
  logic                    overrun_r;
  logic                    start_s;
  logic                    conv_last_s;
  logic [4*NUM_DIGITS-1:0] bcd_s;
  logic                    write_s;
  logic                    busy_s;
  logic [3:0]              digit_s;
  logic [7:0]              char_s;

  assign start_s = (state_r == IDLE) && bus.done;

  bin2bcd_seq #(
    .WIDTH  (WIDTH_SPEED),
    .DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start_s),
    .bin       (bus.speed),
    .bcd       (bcd_s),
    .done_conv (conv_last_s)
  );

`ifdef SPEED_ASCII_LZS_EN
  logic [IDX_W-1:0] first_nz_s;

  // Index of the first nonzero digit, MSD = 0; the last digit is always kept.
  always_comb begin
    first_nz_s = IDX_W'(NUM_DIGITS - 1);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      if (bcd_s[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) begin
        first_nz_s = IDX_W'(i);
      end else begin
        first_nz_s = first_nz_s;
      end
    end
  end

  // Skipped digits cost no cycles: the index is lifted straight past them.
  assign eff_idx_s = (idx_r < first_nz_s) ? first_nz_s : idx_r;
`else
  assign eff_idx_s = idx_r;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.done) state_nx_s = CONVERT;
        else          state_nx_s = IDLE;
      end
      CONVERT: begin
        if (conv_last_s) state_nx_s = EMIT;
        else             state_nx_s = CONVERT;
      end
      EMIT: begin
        if (write_s && (eff_idx_s == LAST_IDX)) state_nx_s = IDLE;
        else                                    state_nx_s = EMIT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Outputs: write is gated only by fifo_full so a full FIFO never sees a write;
  // the byte comes from registered index and BCD, so it holds during a stall.
  always_comb begin
    write_s = (state_r == EMIT) && !bus.fifo_full;
    busy_s  = (state_r != IDLE);
    digit_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (eff_idx_s == IDX_W'(i)) begin
        digit_s = bcd_s[4*(NUM_DIGITS-1-i) +: 4];
      end else begin
        digit_s = digit_s;
      end
    end
    if (state_r != EMIT) begin
      char_s = 8'h00;
    end else if (eff_idx_s < CR_IDX) begin
      char_s = ASCII_ZERO | {4'd0, digit_s};
    end else if (eff_idx_s == CR_IDX) begin
      char_s = ASCII_CR;
    end else begin
      char_s = ASCII_LF;
    end
  end

  // Character index: cleared outside EMIT, advanced only on an accepted write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r <= '0;
    end else if (state_r != EMIT) begin
      idx_r <= '0;
    end else if (write_s) begin
      if (eff_idx_s == LAST_IDX) idx_r <= '0;
      else                       idx_r <= eff_idx_s + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Overrun pulse: a strobe seen while not IDLE is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= bus.done && (state_r != IDLE);
    end
  end

  assign bus.write   = write_s;
  assign bus.busy    = busy_s;
  assign bus.data    = DATA_SIZE'(char_s);
  assign bus.overrun = overrun_r;

endmodule

// File: doc/speed_ascii_framer.md
Name: speed_ascii_framer

Overview:
- Upstream stage of the UART transmit FIFO: takes a binary speed sample with a one-cycle valid strobe and converts it to decimal ASCII.
- Pushes the frame into the FIFO byte by byte (digits, then CR, LF) and respects the FIFO full flag.
- Conversion is sequential double-dabble (shift-add-3), one bit per clock; no dividers.

Parameters:
- WIDTH_SPEED, 14, width of the binary speed input.
- NUM_DIGITS, 5, decimal digits emitted. Must satisfy 10^NUM_DIGITS > 2^WIDTH_SPEED-1; elaboration error otherwise.
- DATA_SIZE, 8, FIFO data width. ASCII is in bits [7:0]; upper bits are zero if wider.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- done  input  1  one-cycle strobe: speed is valid.
- speed  input  WIDTH_SPEED  binary speed value, sampled when done=1 is accepted.
- fifo_full  input  1  FIFO full flag; no write is issued while high.
- write  output  1  FIFO write strobe, one byte per cycle.
- data  output  DATA_SIZE  byte presented with write.
- busy  output  1  high while a frame is in conversion or emission.
- overrun  output  1  one-cycle pulse: done arrived while busy and the sample was dropped.

Behaviour:
- Clock, reset and state:
  - Reset asserts asynchronously and releases on clk. The FSM, shift register and counters are registered on clk.
  - States: IDLE, CONVERT, EMIT.
- Reset:
  - state=IDLE, bcd=0, bit counter=0, char index=0, overrun=0.
  - write=0 and busy=0 immediately on reset assertion.
  - Reset mid-frame abandons the frame; no partial bytes follow.
- IDLE:
  - done=1 latches speed into the shift register, clears BCD digits and goes to CONVERT.
  - done=0 holds IDLE.
- CONVERT: runs exactly WIDTH_SPEED cycles. Each cycle:
  - add 3 to every BCD nibble >=5;
  - then shift {bcd, bin} left by 1.
  - After the last shift, go to EMIT with char index=0.
- EMIT: char index 0..NUM_DIGITS+1.
  - Digits are emitted MSD first as 0x30+nibble, then 0x0D, then 0x0A.
  - write = (state==EMIT) & ~fifo_full. This is combinational from registered state and fifo_full, so it is FIFO-safe with no lookahead.
  - data is driven from the registered index and BCD. It is stable while stalled.
  - The index advances only on a cycle where write=1.
  - fifo_full=1 stalls indefinitely with no byte lost and no duplicate written.
  - After the write of 0x0A, return to IDLE.
- Latency:
  - done at cycle T gives the first write at T+WIDTH_SPEED+1 if the FIFO is not full.
  - An unstalled frame takes NUM_DIGITS+2 consecutive write cycles.
  - busy is high from T+1 through the cycle of the final write.
  - A new done is accepted on the cycle after the final write.
- Simultaneous and overrun cases:
  - done while busy (CONVERT or EMIT) is ignored and overrun pulses for 1 cycle the next clock.
  - done on the same cycle as the final write (state still EMIT) also counts as overrun.
- Width: upper DATA_SIZE-8 bits of data are always 0.

Optional Feature:
- Macro SPEED_ASCII_LZS_EN.
- When defined: leading zero digits are skipped in EMIT. The index jumps to the first nonzero digit with no write cycles for the skipped digits. The last digit is always emitted, so 0 gives "0\r\n".
- When undefined: all NUM_DIGITS digits are emitted with leading zeros, and frame length is fixed at NUM_DIGITS+2.

Decomposition:
- Shared package speed_ascii_pkg holds:
  - state enum (IDLE, CONVERT, EMIT);
  - ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
  - a function computing the minimum digit count, used for the elaboration check.
- One natural sub-module: bin2bcd_seq, the iterative double-dabble engine.
  - Interface: start, bin in, bcd out, done_conv.
  - The framer FSM owns EMIT and the FIFO handshake.

Test Plan:
- speed=12186 (14'b10111110011010), done pulse, fifo_full=0 -> writes 0x31,0x32,0x31,0x38,0x36,0x0D,0x0A on 7 consecutive cycles. First write at T+15; busy low after the last write.
- speed=42, macro undefined -> "00042\r\n" (0x30,0x30,0x30,0x34,0x32,0x0D,0x0A). Macro defined -> 0x34,0x32,0x0D,0x0A. With the macro defined, speed=0 -> 0x30,0x0D,0x0A.
- speed=16383 with fifo_full forced high for 20 cycles at the third byte -> write=0 throughout the stall and data held at 0x33. Afterwards the stream resumes "16383\r\n" exactly once with no duplicates.
- done pulse during CONVERT and again during EMIT -> overrun pulses twice and the first frame is unaltered. done one cycle after the final 0x0A -> accepted, no overrun.
- reset_n low during EMIT after 2 bytes -> write=0 immediately and no further bytes. After release, done with speed=7 -> clean "00007\r\n" (macro undefined).
- Back-to-back done every 7 cycles for 50 samples with random fifo_full -> the FIFO byte stream parses to exactly the accepted samples, and the overrun count equals the dropped strobes.
